// File: rtl/ctrl_sequencer.sv
// Microsequencer for the 8-bit accumulator CPU.
// Moore FSM driving the 32-bit micro-op strobe bus.
module ctrl_sequencer #(
  parameter int WAIT_LIMIT = 255,
  parameter bit AUTO_START = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic        acc_neg,
  input  logic        mem_ready,
  output logic [31:0] control_signal,
  output logic        halted,
  output logic        illegal_op,
  output logic        bus_err,
  output logic [3:0]  state_dbg
);

  localparam int CW =
    (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_JMP   = 8'h05;
  localparam logic [7:0] OP_JGEZ  = 8'h06;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_F1     = 4'd1,
    S_F2     = 4'd2,
    S_F3     = 4'd3,
    S_DEC    = 4'd4,
    S_O1     = 4'd5,
    S_O2     = 4'd6,
    S_O3     = 4'd7,
    S_J      = 4'd8,
    S_A      = 4'd9,
    S_R      = 4'd10,
    S_X      = 4'd11,
    S_W1     = 4'd12,
    S_W2     = 4'd13,
    S_HALTED = 4'd14
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          mem_st;
  logic          timeout;
  logic          set_ill;
  logic          set_bus;

  assign mem_st = (state == S_F2) || (state == S_O2) ||
                  (state == S_R)  || (state == S_W2);

  // A stalled access may sit at the limit only while mem_ready is low
  assign timeout = mem_st && !mem_ready &&
                   (wait_cnt == CW'(WAIT_LIMIT));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sticky error flags and memory wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (set_ill) illegal_op <= 1'b1;
      if (set_bus) bus_err    <= 1'b1;
      if (state != state_nxt) begin
        wait_cnt <= '0;
      end else if (mem_st && !mem_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    set_ill   = 1'b0;
    set_bus   = 1'b0;
    if (timeout) begin
      state_nxt = S_HALTED;
      set_bus   = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start || AUTO_START) state_nxt = S_F1;
        end
        S_F1: state_nxt = S_F2;
        S_F2: begin
          if (mem_ready) state_nxt = S_F3;
        end
        S_F3: state_nxt = S_DEC;
        S_DEC: begin
          case (opcode)
            OP_NOP:  state_nxt = S_F1;
            OP_HALT: state_nxt = S_HALTED;
            OP_LOAD, OP_STORE, OP_ADD,
            OP_SUB, OP_JMP, OP_JGEZ:
              state_nxt = S_O1;
            default: begin
              state_nxt = S_HALTED;
              set_ill   = 1'b1;
            end
          endcase
        end
        S_O1: state_nxt = S_O2;
        S_O2: begin
          if (mem_ready) state_nxt = S_O3;
        end
        S_O3: begin
          case (opcode)
            OP_JMP:  state_nxt = S_J;
            OP_JGEZ: state_nxt = acc_neg ? S_F1 : S_J;
            default: state_nxt = S_A;
          endcase
        end
        S_J: state_nxt = S_F1;
        S_A: begin
          state_nxt = (opcode == OP_STORE) ? S_W1 : S_R;
        end
        S_R: begin
          if (mem_ready) state_nxt = S_X;
        end
        S_X:  state_nxt = S_F1;
        S_W1: state_nxt = S_W2;
        S_W2: begin
          if (mem_ready) state_nxt = S_F1;
        end
        S_HALTED: state_nxt = S_HALTED;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Strobe decode from the registered state
  always_comb begin
    control_signal = '0;
    unique case (state)
      S_F1: control_signal[2] = 1'b1;
      S_F2: control_signal[4] = 1'b1;
      S_F3: begin
        control_signal[6]  = 1'b1;
        control_signal[20] = 1'b1;
      end
      S_O1: control_signal[2]  = 1'b1;
      S_O2: control_signal[4]  = 1'b1;
      S_O3: control_signal[20] = 1'b1;
      S_J:  control_signal[3]  = 1'b1;
      S_A:  control_signal[0]  = 1'b1;
      S_R:  control_signal[4]  = 1'b1;
      S_X: begin
        case (opcode)
          OP_LOAD: control_signal[7] = 1'b1;
          OP_ADD:  control_signal[8] = 1'b1;
          OP_SUB:  control_signal[9] = 1'b1;
          default: control_signal    = '0;
        endcase
      end
      S_W1: control_signal[10] = 1'b1;
      S_W2: control_signal[5]  = 1'b1;
      default: control_signal  = '0;
    endcase
  end

  assign halted    = (state == S_HALTED);
  assign state_dbg = state;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: per-instruction strobe
// sequences built from opcode rules, random waits.
module tb_ctrl_sequencer;

  localparam int WL = 4;

  localparam logic [31:0] C0  = 32'h0000_0001;
  localparam logic [31:0] C2  = 32'h0000_0004;
  localparam logic [31:0] C3  = 32'h0000_0008;
  localparam logic [31:0] C4  = 32'h0000_0010;
  localparam logic [31:0] C5  = 32'h0000_0020;
  localparam logic [31:0] C6  = 32'h0000_0040;
  localparam logic [31:0] C7  = 32'h0000_0080;
  localparam logic [31:0] C8  = 32'h0000_0100;
  localparam logic [31:0] C9  = 32'h0000_0200;
  localparam logic [31:0] C10 = 32'h0000_0400;
  localparam logic [31:0] C20 = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        acc_neg = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] control_signal;
  logic        halted;
  logic        illegal_op;
  logic        bus_err;
  logic [3:0]  state_dbg;

  int nchk  = 0;
  int npass = 0;
  int wait_fixed = -1;

  logic [31:0] exp_cs[$];
  logic        exp_mr[$];

  ctrl_sequencer #(
    .WAIT_LIMIT(WL),
    .AUTO_START(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .opcode(opcode),
    .acc_neg(acc_neg),
    .mem_ready(mem_ready),
    .control_signal(control_signal),
    .halted(halted),
    .illegal_op(illegal_op),
    .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  function automatic logic [31:0] flags();
    return 32'({halted, illegal_op, bus_err});
  endfunction

  function automatic void push_plain(logic [31:0] s);
    exp_cs.push_back(s);
    exp_mr.push_back(1'($urandom_range(0, 1)));
  endfunction

  function automatic void push_mem(logic [31:0] s);
    int w;
    w = (wait_fixed < 0) ? int'($urandom_range(0, 3))
                         : wait_fixed;
    for (int i = 0; i < w; i++) begin
      exp_cs.push_back(s);
      exp_mr.push_back(1'b0);
    end
    exp_cs.push_back(s);
    exp_mr.push_back(1'b1);
  endfunction

  // Cycle-by-cycle strobes of one instruction
  function automatic void build(logic [7:0] op,
                                logic neg);
    push_plain(C2);
    push_mem(C4);
    push_plain(C6 | C20);
    push_plain(32'h0);
    if (op >= 8'h01 && op <= 8'h06) begin
      push_plain(C2);
      push_mem(C4);
      push_plain(C20);
      if (op == 8'h05 || (op == 8'h06 && !neg)) begin
        push_plain(C3);
      end else if (op == 8'h02) begin
        push_plain(C0);
        push_plain(C10);
        push_mem(C5);
      end else if (op != 8'h06) begin
        push_plain(C0);
        push_mem(C4);
        case (op)
          8'h01:   push_plain(C7);
          8'h03:   push_plain(C8);
          default: push_plain(C9);
        endcase
      end
    end
  endfunction

  task automatic play();
    while (exp_cs.size() > 0) begin
      logic [31:0] e;
      e = exp_cs.pop_front();
      mem_ready = exp_mr.pop_front();
      start = 1'($urandom_range(0, 1));
      chk("cs", control_signal, e);
      chk("flags", flags(), 32'h0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic run(input logic [7:0] op,
                     input logic neg);
    opcode  = op;
    acc_neg = neg;
    build(op, neg);
    play();
  endtask

  task automatic do_reset();
    start     = 1'b0;
    mem_ready = 1'b0;
    rst = 1'b0;
    #3;
    chk("rst_cs", control_signal, 32'h0);
    chk("rst_flags", flags(), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("idle_cs", control_signal, 32'h0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    pulse_start();

    wait_fixed = 0;
    run(8'h00, 1'b0);
    run(8'h01, 1'b0);
    run(8'h06, 1'b1);
    run(8'h06, 1'b0);
    run(8'h05, 1'b0);
    wait_fixed = 3;
    run(8'h02, 1'b0);
    wait_fixed = -1;
    for (int i = 0; i < 40; i++) begin
      run(8'($urandom_range(0, 6)),
          1'($urandom_range(0, 1)));
    end
    chk("f1_back", control_signal, C2);

    run(8'hFF, 1'b0);
    chk("halt_cs", control_signal, 32'h0);
    chk("halt_flags", flags(), 32'h4);
    pulse_start();
    chk("halt_stay", flags(), 32'h4);

    do_reset();
    pulse_start();
    mem_ready = 1'b0;
    chk("to_f1", control_signal, C2);
    @(posedge clk);
    #1;
    for (int i = 0; i <= WL; i++) begin
      chk("to_wait", control_signal, C4);
      @(posedge clk);
      #1;
    end
    chk("to_cs", control_signal, 32'h0);
    chk("to_flags", flags(), 32'h5);

    do_reset();
    pulse_start();
    run(8'h7A, 1'b0);
    chk("ill_cs", control_signal, 32'h0);
    chk("ill_flags", flags(), 32'h6);

    do_reset();
    pulse_start();
    wait_fixed = 0;
    opcode = 8'h01;
    build(8'h01, 1'b0);
    void'(exp_cs.pop_back());
    void'(exp_mr.pop_back());
    void'(exp_cs.pop_back());
    void'(exp_mr.pop_back());
    play();
    mem_ready = 1'b0;
    chk("r_cs", control_signal, C4);
    #2;
    rst = 1'b0;
    #1;
    chk("midr_cs", control_signal, 32'h0);
    chk("midr_flags", flags(), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
